// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, controller
// states and default latencies.
package md_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 4;

    // Multi-cycle ops are the ones that occupy the unit (MULT..DIVU).
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op >= 3'(OP_MULT)) && (op <= 3'(OP_DIVU));
    endfunction

    function automatic logic is_mult_op(input logic [2:0] op);
        return (op == 3'(OP_MULT)) || (op == 3'(OP_MULTU));
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result generator for the latched MD operation,
// including the divide-by-zero and signed-overflow cases.
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic signed [WIDTH-1:0]   div_b_s;
    logic [WIDTH-1:0]          div_b_u;
    logic signed [WIDTH-1:0]   quot_s;
    logic signed [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]          quot_u;
    logic [WIDTH-1:0]          rem_u;
    logic                      div_zero;
    logic                      div_ovf;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign div_zero = (b == '0);
    assign div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    // Divisors are sanitised so the dividers never see the undefined cases;
    // those results are substituted below instead.
    assign div_b_s = (div_zero || div_ovf) ? WIDTH'(1) : b;
    assign div_b_u = div_zero ? WIDTH'(1) : b;
    assign quot_s  = $signed(a) / div_b_s;
    assign rem_s   = $signed(a) % div_b_s;
    assign quot_u  = a / div_b_u;
    assign rem_u   = a % div_b_u;

    always_comb begin
        hi_next = '0;
        lo_next = '0;
        case (op)
            3'(OP_MULT):  {hi_next, lo_next} = prod_s;
            3'(OP_MULTU): {hi_next, lo_next} = prod_u;
            3'(OP_DIV): begin
                if (div_zero) begin
                    hi_next = a;
                    lo_next = '1;
                end else if (div_ovf) begin
                    hi_next = '0;
                    lo_next = a;
                end else begin
                    hi_next = rem_s;
                    lo_next = quot_s;
                end
            end
            3'(OP_DIVU): begin
                if (div_zero) begin
                    hi_next = a;
                    lo_next = '1;
                end else begin
                    hi_next = rem_u;
                    lo_next = quot_u;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencing controller: owns HI/LO, models op latency and
// stalls D-stage MD instructions. Optional cancel port under MD_CANCEL_EN.
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             d_uses_md,
`ifdef MD_CANCEL_EN
    input  logic             md_cancel,
`endif
    output logic             busy,
    output logic             stall_d,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       op_reg, op_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             cancel_w;

`ifdef MD_CANCEL_EN
    assign cancel_w = md_cancel;
`else
    assign cancel_w = 1'b0;
`endif

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op      (op_reg),
        .a       (a_reg),
        .b       (b_reg),
        .hi_next (res_hi),
        .lo_next (res_lo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                // A start seen while RUN is never examined, so it is ignored.
                if (start && !cancel_w) begin
                    if (is_arith_op(md_op)) begin
                        state_next = ST_RUN;
                        cnt_next   = is_mult_op(md_op) ? CNT_W'(MULT_CYCLES)
                                                       : CNT_W'(DIV_CYCLES);
                        op_next    = md_op;
                        a_next     = rs_val;
                        b_next     = rt_val;
                    end else if (md_op == 3'(OP_MTHI)) begin
                        hi_next = rs_val;
                    end else if (md_op == 3'(OP_MTLO)) begin
                        lo_next = rs_val;
                    end
                end
            end
            ST_RUN: begin
                if (cancel_w) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    hi_next    = res_hi;
                    lo_next    = res_lo;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy    = (state_reg == ST_RUN);
    // Covers the start cycle too, so a trailing mfhi/mflo never reads stale HI/LO.
    assign stall_d = d_uses_md & (busy | (start & is_arith_op(md_op)));
    assign hi      = hi_reg;
    assign lo      = lo_reg;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed cases plus randomized ops
// checked every cycle against a behavioural HI/LO and latency model.
module tb_md_unit_ctrl;
    import md_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MD_CANCEL_EN
    localparam bit CANCEL_ON = 1'b1;
`else
    localparam bit CANCEL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        d_uses_md = 1'b0;
`ifdef MD_CANCEL_EN
    logic        md_cancel = 1'b0;
`endif
    logic        busy;
    logic        stall_d;
    logic [31:0] hi;
    logic [31:0] lo;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model state
    int          busy_left = 0;
    logic [63:0] pend = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    md_unit_ctrl #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .md_op     (md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .d_uses_md (d_uses_md),
`ifdef MD_CANCEL_EN
        .md_cancel (md_cancel),
`endif
        .busy      (busy),
        .stall_d   (stall_d),
        .hi        (hi),
        .lo        (lo)
    );

    always @(posedge clk) begin
        if (reset_n && start && busy)
            $error("start issued while busy");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {hi, lo} straight from the arithmetic definitions.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, ma, mb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if ((op == 3'd3 || op == 3'd4) && b == 32'd0)
            return {a, 32'hFFFF_FFFF};
        case (op)
            3'd1: return 64'(sa * sb);
            3'd2: return 64'(ua * ub);
            3'd3: begin
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                q = ma / mb;
                r = ma % mb;
                if ((sa < 0) != (sb < 0)) q = -q;
                if (sa < 0) r = -r;
                return {r[31:0], q[31:0]};
            end
            3'd4: return {32'(ua % ub), 32'(ua / ub)};
            default: return 64'd0;
        endcase
    endfunction

    // One clock cycle: drive at negedge, check stall, then advance model and check state.
    task automatic step(input logic s, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic dum, input logic canc);
        logic arith;
        logic kill;
        @(negedge clk);
        start     = s;
        md_op     = op;
        rs_val    = a;
        rt_val    = b;
        d_uses_md = dum;
`ifdef MD_CANCEL_EN
        md_cancel = canc;
`endif
        arith = s && (op >= 3'd1) && (op <= 3'd4);
        kill  = canc && CANCEL_ON;
        #1;
        check_eq("stall_d", 32'(stall_d), 32'(dum && ((busy_left > 0) || arith)));
        @(posedge clk);
        #1;
        if (busy_left > 0) begin
            if (kill) begin
                busy_left = 0;
            end else begin
                busy_left--;
                if (busy_left == 0) begin
                    m_hi = pend[63:32];
                    m_lo = pend[31:0];
                end
            end
        end else if (s && !kill) begin
            if (op == 3'd1 || op == 3'd2) begin
                busy_left = MC;
                pend = ref_result(op, a, b);
            end else if (op == 3'd3 || op == 3'd4) begin
                busy_left = DC;
                pend = ref_result(op, a, b);
            end else if (op == 3'd5) begin
                m_hi = a;
            end else if (op == 3'd6) begin
                m_lo = a;
            end
        end
        if (s)
            $display("txn op=%0d rs=%h rt=%h cancel=%0d -> busy=%0d hi=%h lo=%h",
                     op, a, b, kill, busy, hi, lo);
        check_eq("busy", 32'(busy), 32'(busy_left > 0));
        check_eq("hi", hi, m_hi);
        check_eq("lo", lo, m_lo);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = (op == 3'd1 || op == 3'd2) ? MC : DC;
        step(1'b1, op, a, b, 1'b1, 1'b0);
        repeat (n) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        start   = 1'b0;
        #1;
        busy_left = 0;
        m_hi = '0;
        m_lo = '0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        d_uses_md = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("init_busy", 32'(busy), 32'd0);
        check_eq("init_stall", 32'(stall_d), 32'd0);
        check_eq("init_hi", hi, 32'd0);
        check_eq("init_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        check_eq("mult_hi", hi, 32'hFFFF_FFFF);
        check_eq("mult_lo", lo, 32'hFFFF_FFFA);
        step(1'b1, 3'd6, 32'h0000_1234, 32'd0, 1'b1, 1'b0);
        check_eq("mtlo_lo", lo, 32'h0000_1234);

        run_op(3'd4, 32'd100, 32'd7);
        check_eq("divu_lo", lo, 32'd14);
        check_eq("divu_hi", hi, 32'd2);
        run_op(3'd4, 32'd100, 32'd0);
        check_eq("divu0_lo", lo, 32'hFFFF_FFFF);
        check_eq("divu0_hi", hi, 32'd100);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        check_eq("div_lo", lo, 32'hFFFF_FFFD);
        check_eq("div_hi", hi, 32'hFFFF_FFFF);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("divovf_lo", lo, 32'h8000_0000);
        check_eq("divovf_hi", hi, 32'd0);

        step(1'b1, 3'd3, 32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (3) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        async_reset();
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        check_eq("multu_hi", hi, 32'd1);
        check_eq("multu_lo", lo, 32'hFFFF_FFFE);

`ifdef MD_CANCEL_EN
        step(1'b1, 3'd5, 32'h11, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd6, 32'h22, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 32'd7, 32'd9, 1'b0, 1'b0);
        repeat (2) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check_eq("cancel_busy", 32'(busy), 32'd0);
        check_eq("cancel_hi", hi, 32'h11);
        check_eq("cancel_lo", lo, 32'h22);
        step(1'b1, 3'd5, 32'h99, 32'd0, 1'b0, 1'b1);
        check_eq("cancel_mthi", hi, 32'h11);
`endif

        for (int i = 0; i < 400; i++) begin
            if (busy_left == 0 && $urandom_range(0, 2) == 0)
                step(1'b1, 3'($urandom_range(0, 7)), pick(), pick(),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
            else
                step(1'b0, 3'd0, pick(), pick(),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
